// File: rtl/ysyx_23060184_lsu.sv
// rtl/ysyx_23060184_lsu.sv - load/store unit with region decode, bus arbitration and AXI4-Lite master
module ysyx_23060184_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS*32-1:0] REGION_BASE = {32'hA000_03F8, 32'h8000_0000},
  parameter logic [NUM_REGIONS*32-1:0] REGION_MASK = {32'hFFFF_FFF8, 32'hF800_0000}
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            addr,
  input  logic [DATA_WIDTH-1:0]  wdata_in,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [1:0]             size,
  input  logic                   is_unsigned,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   fault,
  output logic [1:0]             fault_cause,
  output logic                   req,
  input  logic                   grant,
  output logic [31:0]            araddr,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [DATA_WIDTH-1:0]  rdata,
  input  logic [1:0]             rresp,
  input  logic                   rvalid,
  output logic                   rready,
  output logic [31:0]            awaddr,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [DATA_WIDTH-1:0]  wdata,
  output logic [3:0]             wstrb,
  output logic                   wvalid,
  input  logic                   wready,
  input  logic [1:0]             bresp,
  input  logic                   bvalid,
  output logic                   bready,
  output logic [NUM_REGIONS-1:0] region_sel
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_RADDR, S_RDATA, S_WRITE, S_WRESP, S_DONE
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_DECODE   = 2'd2;
  localparam logic [1:0] CAUSE_BUS      = 2'd3;

  state_t                 state;
  logic [31:0]            addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic                   read_q;
  logic [1:0]             size_q;
  logic                   uns_q;

  logic                   misaligned;
  logic                   dec_hit;
  logic [NUM_REGIONS-1:0] dec_sel;
  logic [DATA_WIDTH-1:0]  shifted;
  logic [DATA_WIDTH-1:0]  load_val;
  logic [DATA_WIDTH-1:0]  st_data;
  logic [3:0]             st_strb;

  // Scan from the top so the lowest-index matching region is the one that sticks.
  always_comb begin
    dec_sel = '0;
    dec_hit = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((addr & REGION_MASK[i*32 +: 32]) == REGION_BASE[i*32 +: 32]) begin
        dec_sel    = '0;
        dec_sel[i] = 1'b1;
        dec_hit    = 1'b1;
      end
    end
  end

  always_comb begin
    misaligned = (size == 2'd1 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
  end

  always_comb begin
    shifted = rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'd0:    load_val = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'd1:    load_val = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0: begin
        st_data = {4{wdata_q[7:0]}};
        st_strb = 4'b0001 << addr_q[1:0];
      end
      2'd1: begin
        st_data = {2{wdata_q[15:0]}};
        st_strb = 4'b0011 << addr_q[1:0];
      end
      default: begin
        st_data = wdata_q;
        st_strb = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= S_IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      result      <= '0;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
      req         <= 1'b0;
      araddr      <= '0;
      arvalid     <= 1'b0;
      rready      <= 1'b0;
      awaddr      <= '0;
      awvalid     <= 1'b0;
      wdata       <= '0;
      wstrb       <= '0;
      wvalid      <= 1'b0;
      bready      <= 1'b0;
      region_sel  <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_q      <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            addr_q   <= addr;
            wdata_q  <= wdata_in;
            read_q   <= mem_read;
            size_q   <= size;
            uns_q    <= is_unsigned;
            if (!mem_read && !mem_write) begin
              result      <= addr;
              fault       <= 1'b0;
              fault_cause <= CAUSE_NONE;
              out_valid   <= 1'b1;
              state       <= S_DONE;
            end else if (misaligned) begin
              result      <= '0;
              fault       <= 1'b1;
              fault_cause <= CAUSE_MISALIGN;
              out_valid   <= 1'b1;
              state       <= S_DONE;
            end else if (!dec_hit) begin
              result      <= '0;
              fault       <= 1'b1;
              fault_cause <= CAUSE_DECODE;
              out_valid   <= 1'b1;
              state       <= S_DONE;
            end else begin
              req        <= 1'b1;
              region_sel <= dec_sel;
              state      <= S_ARB;
            end
          end
        end
        S_ARB: begin
          if (grant) begin
            if (read_q) begin
              araddr  <= {addr_q[31:2], 2'b00};
              arvalid <= 1'b1;
              state   <= S_RADDR;
            end else begin
              awaddr  <= {addr_q[31:2], 2'b00};
              wdata   <= st_data;
              wstrb   <= st_strb;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= S_WRITE;
            end
          end
        end
        S_RADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (rvalid) begin
            rready      <= 1'b0;
            result      <= load_val;
            fault       <= (rresp != 2'b00);
            fault_cause <= (rresp != 2'b00) ? CAUSE_BUS : CAUSE_NONE;
            out_valid   <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_WRITE: begin
          // A channel whose valid is already low has completed its handshake.
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready) wvalid <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready <= 1'b1;
            state  <= S_WRESP;
          end
        end
        S_WRESP: begin
          if (bvalid) begin
            bready      <= 1'b0;
            result      <= '0;
            fault       <= (bresp != 2'b00);
            fault_cause <= (bresp != 2'b00) ? CAUSE_BUS : CAUSE_NONE;
            out_valid   <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            req        <= 1'b0;
            region_sel <= '0;
            in_ready   <= 1'b1;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060184_lsu.sv
// tb/tb_ysyx_23060184_lsu.sv - randomized self-checking bench for ysyx_23060184_lsu
module tb_ysyx_23060184_lsu;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid, in_ready, mem_read, mem_write, is_unsigned;
  logic [31:0] addr, wdata_in, result, araddr, rdata, awaddr, wdata;
  logic [1:0] size, fault_cause, rresp, bresp, region_sel;
  logic out_valid, out_ready, fault, req, grant;
  logic arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0] wstrb;

  always #5 clk = ~clk;

  ysyx_23060184_lsu dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .addr(addr),
    .wdata_in(wdata_in), .mem_read(mem_read), .mem_write(mem_write), .size(size),
    .is_unsigned(is_unsigned), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .fault(fault), .fault_cause(fault_cause), .req(req), .grant(grant), .araddr(araddr),
    .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .rready(rready), .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .wdata(wdata),
    .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid),
    .bready(bready), .region_sel(region_sel)
  );

  typedef struct packed {
    logic [1:0]  cause;
    logic [31:0] result;
    logic [1:0]  region;
    logic        bus;
    logic        is_rd;
    logic [31:0] araddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } exp_t;

  int n_checks = 0;
  int n_pass = 0;

  int o_lat, o_wait;
  logic o_timeout, o_saw_ar, o_saw_aw, o_proto, o_stable, o_aw_first, o_wresp_early;
  logic o_idle_ok, o_fault, o_ready_done;
  logic [31:0] o_result, o_araddr, o_awaddr, o_wdata;
  logic [3:0] o_wstrb;
  logic [1:0] o_cause, o_region, o_region_arb;

  // Expected outcome computed straight from the access rules with plain arithmetic.
  function automatic exp_t model(input logic [31:0] a, input logic rd, input logic wr,
                                 input logic [1:0] sz, input logic uns, input logic [31:0] wd,
                                 input logic [31:0] rdv, input logic [1:0] rr, input logic [1:0] br);
    exp_t e;
    int nb, lane, hit;
    longint v;
    e = '0;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lane = int'(a % 4);
    if (!rd && !wr) begin e.result = a; return e; end
    if (a % nb != 0) begin e.cause = 2'd1; return e; end
    hit = -1;
    if ((a & 32'hF800_0000) == 32'h8000_0000) hit = 0;
    else if ((a & 32'hFFFF_FFF8) == 32'hA000_03F8) hit = 1;
    if (hit < 0) begin e.cause = 2'd2; return e; end
    e.region = (hit == 0) ? 2'b01 : 2'b10;
    e.bus = 1'b1;
    e.is_rd = rd;
    if (rd) begin
      e.araddr = a - 32'(lane);
      v = (longint'(rdv) >> (8 * lane)) & ((longint'(1) << (8 * nb)) - 1);
      if (!uns && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
      e.result = v[31:0];
      e.cause = (rr != 2'b00) ? 2'd3 : 2'd0;
    end else begin
      e.wstrb = 4'(((1 << nb) - 1) << lane);
      e.wdata = (nb == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                (nb == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
      e.result = 32'h0;
      e.cause = (br != 2'b00) ? 2'd3 : 2'd0;
    end
    return e;
  endfunction

  task automatic clear_slave();
    grant = 0; arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0; out_ready = 0;
    rdata = 0; rresp = 0; bresp = 0;
  endtask

  // Drives one request, plays arbiter/slave/consumer with the given delays, records what it sees.
  task automatic run_txn(input logic [31:0] a, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] wd, input logic [31:0] rdv,
                         input logic [1:0] rr, input logic [1:0] br, input int gd, input int ard,
                         input int rdd, input int awd, input int wdd, input int bd, input int hold);
    int cyc, gc, arc, rc, awc, wc, bc, oc;
    logic seen, done, aw_hs, w_hs;
    logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr, p_ov, p_or;
    o_timeout = 0; o_lat = -1; o_wait = 0; o_saw_ar = 0; o_saw_aw = 0; o_proto = 0;
    o_stable = 1; o_aw_first = 0; o_wresp_early = 0; o_idle_ok = 0; o_result = 0; o_fault = 0;
    o_cause = 0; o_region = 0; o_region_arb = 0; o_ready_done = 0; o_araddr = 0; o_awaddr = 0;
    o_wdata = 0; o_wstrb = 0;
    while (!in_ready && o_wait < 20) begin @(negedge clk); o_wait++; end
    in_valid = 1; addr = a; mem_read = rd; mem_write = wr; size = sz; is_unsigned = uns; wdata_in = wd;
    @(negedge clk);
    in_valid = 0; addr = $urandom(); wdata_in = $urandom(); mem_read = 1'($urandom());
    mem_write = 1'($urandom()); size = 2'($urandom()); is_unsigned = 1'($urandom());
    cyc = 1; gc = 0; arc = 0; rc = 0; awc = 0; wc = 0; bc = 0; oc = 0;
    seen = 0; done = 0; aw_hs = 0; w_hs = 0;
    p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_ov = 0; p_or = 0;
    while (!done && cyc < 200) begin
      if (p_ov && p_or) begin
        o_idle_ok = !out_valid && in_ready && region_sel == 2'b00 && !req;
        done = 1;
      end else begin
        if (p_awv && p_awr) aw_hs = 1;
        if (p_wv && p_wr) w_hs = 1;
        if ((p_arv && !p_arr && !arvalid) || (p_awv && !p_awr && !awvalid) ||
            (p_wv && !p_wr && !wvalid)) o_proto = 1;
        if (arvalid) begin o_saw_ar = 1; o_araddr = araddr; end
        if (awvalid || wvalid) begin o_saw_aw = 1; o_wdata = wdata; o_wstrb = wstrb; end
        if (awvalid) o_awaddr = awaddr;
        if (!awvalid && wvalid && aw_hs) o_aw_first = 1;
        if (bready && !(aw_hs && w_hs)) o_wresp_early = 1;
        if (cyc == 1) o_region_arb = region_sel;
        if (out_valid) begin
          if (!seen) begin
            seen = 1; o_lat = cyc; o_result = result; o_fault = fault; o_cause = fault_cause;
            o_region = region_sel; o_ready_done = in_ready;
          end else if (result !== o_result || fault !== o_fault || fault_cause !== o_cause ||
                       region_sel !== o_region || in_ready !== 1'b0) begin
            o_stable = 0;
          end
        end
        grant = req && (gc >= gd); if (req) gc++;
        arready = arvalid && (arc >= ard); if (arvalid) arc++;
        rvalid = rready && (rc >= rdd); if (rready) rc++;
        rdata = rvalid ? rdv : $urandom(); rresp = rr;
        awready = awvalid && (awc >= awd); if (awvalid) awc++;
        wready = wvalid && (wc >= wdd); if (wvalid) wc++;
        bvalid = bready && (bc >= bd); if (bready) bc++;
        bresp = br;
        out_ready = out_valid && (oc >= hold); if (out_valid) oc++;
        p_arv = arvalid; p_arr = arready; p_awv = awvalid; p_awr = awready;
        p_wv = wvalid; p_wr = wready; p_ov = out_valid; p_or = out_ready;
        @(negedge clk);
        cyc++;
      end
    end
    clear_slave();
    if (!done) begin
      o_timeout = 1;
      rstn = 0; @(negedge clk); rstn = 1; @(negedge clk);
    end
  endtask

  task automatic test_reset();
    in_valid = 0; addr = 0; wdata_in = 0; mem_read = 0; mem_write = 0; size = 0; is_unsigned = 0;
    clear_slave();
    rstn = 0;
    @(negedge clk); @(negedge clk);
    n_checks++; if ({out_valid, req, arvalid, rready, awvalid, wvalid, bready, fault} !== 8'h0) $display("FAIL reset_ctrl got=%b exp=0", {out_valid, req, arvalid, rready, awvalid, wvalid, bready, fault}); else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else n_pass++;
    n_checks++; if (result !== 32'h0 || fault_cause !== 2'd0) $display("FAIL reset_result got=%h/%0d exp=0/0", result, fault_cause); else n_pass++;
    n_checks++; if (region_sel !== 2'b00) $display("FAIL reset_region got=%b exp=00", region_sel); else n_pass++;
    rstn = 1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got=%b exp=1", in_ready); else n_pass++;
  endtask

  task automatic test_load_byte();
    run_txn(32'h8000_0003, 1, 0, 2'd0, 0, 32'h0, 32'h80FF_FF7F, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (o_timeout !== 1'b0) $display("FAIL lb_timeout got=%b exp=0", o_timeout); else n_pass++;
    n_checks++; if (o_result !== 32'hFFFF_FF80) $display("FAIL lb_result got=%h exp=ffffff80", o_result); else n_pass++;
    n_checks++; if (o_region !== 2'b01) $display("FAIL lb_region got=%b exp=01", o_region); else n_pass++;
    n_checks++; if (o_cause !== 2'd0 || o_fault !== 1'b0) $display("FAIL lb_cause got=%0d/%b exp=0/0", o_cause, o_fault); else n_pass++;
    n_checks++; if (o_lat != 4) $display("FAIL lb_latency got=%0d exp=4", o_lat); else n_pass++;
    n_checks++; if (o_araddr !== 32'h8000_0000) $display("FAIL lb_araddr got=%h exp=80000000", o_araddr); else n_pass++;
  endtask

  task automatic test_store_half();
    run_txn(32'hA000_03FA, 0, 1, 2'd1, 0, 32'h0000_1234, 32'h0, 2'b00, 2'b00, 1, 0, 0, 1, 0, 1, 1);
    n_checks++; if (o_wdata !== 32'h1234_1234) $display("FAIL sh_wdata got=%h exp=12341234", o_wdata); else n_pass++;
    n_checks++; if (o_wstrb !== 4'b1100) $display("FAIL sh_wstrb got=%b exp=1100", o_wstrb); else n_pass++;
    n_checks++; if (o_region !== 2'b10) $display("FAIL sh_region got=%b exp=10", o_region); else n_pass++;
    n_checks++; if (o_cause !== 2'd0 || o_result !== 32'h0) $display("FAIL sh_done got=%0d/%h exp=0/0", o_cause, o_result); else n_pass++;
  endtask

  task automatic test_store_split();
    run_txn(32'h8000_0010, 0, 1, 2'd2, 0, 32'hCAFE_F00D, 32'h0, 2'b00, 2'b00, 0, 0, 0, 0, 3, 0, 0);
    n_checks++; if (o_aw_first !== 1'b1) $display("FAIL sw_aw_dropped_w_held got=%b exp=1", o_aw_first); else n_pass++;
    n_checks++; if (o_wresp_early !== 1'b0) $display("FAIL sw_wresp_early got=%b exp=0", o_wresp_early); else n_pass++;
    n_checks++; if (o_proto !== 1'b0) $display("FAIL sw_protocol got=%b exp=0", o_proto); else n_pass++;
    n_checks++; if (o_wdata !== 32'hCAFE_F00D || o_wstrb !== 4'hF) $display("FAIL sw_data got=%h/%b exp=cafef00d/1111", o_wdata, o_wstrb); else n_pass++;
  endtask

  task automatic test_fault_paths();
    run_txn(32'h8000_0002, 1, 0, 2'd2, 0, 32'h0, 32'h0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (o_cause !== 2'd1 || o_fault !== 1'b1) $display("FAIL mis_cause got=%0d/%b exp=1/1", o_cause, o_fault); else n_pass++;
    n_checks++; if (o_lat != 1) $display("FAIL mis_latency got=%0d exp=1", o_lat); else n_pass++;
    n_checks++; if (o_saw_ar !== 1'b0) $display("FAIL mis_arvalid got=%b exp=0", o_saw_ar); else n_pass++;
    run_txn(32'h1000_0000, 1, 0, 2'd2, 0, 32'h0, 32'h0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (o_cause !== 2'd2 || o_fault !== 1'b1) $display("FAIL miss_cause got=%0d/%b exp=2/1", o_cause, o_fault); else n_pass++;
    n_checks++; if (o_lat != 1 || o_saw_ar !== 1'b0) $display("FAIL miss_path got=%0d/%b exp=1/0", o_lat, o_saw_ar); else n_pass++;
    run_txn(32'h1234_5678, 0, 0, 2'd2, 0, 32'h0, 32'h0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (o_result !== 32'h1234_5678 || o_fault !== 1'b0) $display("FAIL noop_result got=%h/%b exp=12345678/0", o_result, o_fault); else n_pass++;
  endtask

  task automatic test_bus_error();
    run_txn(32'h8000_0100, 1, 0, 2'd2, 0, 32'h0, 32'hDEAD_BEEF, 2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 5);
    n_checks++; if (o_fault !== 1'b1 || o_cause !== 2'd3) $display("FAIL berr_cause got=%b/%0d exp=1/3", o_fault, o_cause); else n_pass++;
    n_checks++; if (o_stable !== 1'b1) $display("FAIL berr_stable got=%b exp=1", o_stable); else n_pass++;
    n_checks++; if (o_ready_done !== 1'b0) $display("FAIL berr_in_ready got=%b exp=0", o_ready_done); else n_pass++;
    n_checks++; if (o_idle_ok !== 1'b1) $display("FAIL berr_idle_after got=%b exp=1", o_idle_ok); else n_pass++;
  endtask

  task automatic test_random();
    exp_t e;
    logic [31:0] a, wd, rdv;
    logic rd, wr, uns;
    logic [1:0] sz, rr, br;
    int k, op, nb;
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 4);
      a = (k < 2) ? (32'h8000_0000 | ($urandom() & 32'h07FF_FFFF)) :
          (k < 4) ? (32'hA000_03F8 + 32'($urandom_range(0, 7))) : $urandom();
      sz = 2'($urandom_range(0, 2));
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(nb) - 32'd1);
      op = $urandom_range(0, 7);
      rd = (op == 1) || (op >= 2 && op <= 4);
      wr = (op == 1) || (op >= 5);
      uns = 1'($urandom()); wd = $urandom(); rdv = $urandom();
      rr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      br = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      run_txn(a, rd, wr, sz, uns, wd, rdv, rr, br, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 2));
      e = model(a, rd, wr, sz, uns, wd, rdv, rr, br);
      n_checks++; if (o_timeout !== 1'b0) $display("FAIL rnd%0d_timeout got=%b exp=0", i, o_timeout); else n_pass++;
      n_checks++; if (o_cause !== e.cause || o_fault !== (e.cause != 2'd0)) $display("FAIL rnd%0d_cause a=%h got=%0d/%b exp=%0d", i, a, o_cause, o_fault, e.cause); else n_pass++;
      if (e.cause != 2'd3) begin
        n_checks++; if (o_result !== e.result) $display("FAIL rnd%0d_result a=%h got=%h exp=%h", i, a, o_result, e.result); else n_pass++;
      end
      n_checks++; if (o_region !== e.region) $display("FAIL rnd%0d_region got=%b exp=%b", i, o_region, e.region); else n_pass++;
      n_checks++; if (o_saw_ar !== (e.bus && e.is_rd) || o_saw_aw !== (e.bus && !e.is_rd)) $display("FAIL rnd%0d_traffic got=%b%b exp=%b%b", i, o_saw_ar, o_saw_aw, e.bus && e.is_rd, e.bus && !e.is_rd); else n_pass++;
      if (e.bus && e.is_rd) begin
        n_checks++; if (o_araddr !== e.araddr) $display("FAIL rnd%0d_araddr got=%h exp=%h", i, o_araddr, e.araddr); else n_pass++;
      end
      if (e.bus && !e.is_rd) begin
        n_checks++; if (o_wdata !== e.wdata || o_wstrb !== e.wstrb) $display("FAIL rnd%0d_wdata got=%h/%b exp=%h/%b", i, o_wdata, o_wstrb, e.wdata, e.wstrb); else n_pass++;
        n_checks++; if (o_awaddr[31:2] !== a[31:2] || o_wresp_early !== 1'b0) $display("FAIL rnd%0d_aw got=%h/%b exp=%h/0", i, o_awaddr, o_wresp_early, a); else n_pass++;
      end
      if (e.bus) begin
        n_checks++; if (o_region_arb !== e.region) $display("FAIL rnd%0d_region_arb got=%b exp=%b", i, o_region_arb, e.region); else n_pass++;
      end else begin
        n_checks++; if (o_lat != 1) $display("FAIL rnd%0d_fast_latency got=%0d exp=1", i, o_lat); else n_pass++;
      end
      n_checks++; if (o_proto !== 1'b0 || o_stable !== 1'b1 || o_idle_ok !== 1'b1) $display("FAIL rnd%0d_handshake got=%b%b%b exp=011", i, o_proto, o_stable, o_idle_ok); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [31:0] a, rdv;
    for (int i = 0; i < 6; i++) begin
      a = 32'h8000_0000 | ($urandom() & 32'h07FF_FFFC);
      rdv = $urandom();
      run_txn(a, 1, 0, 2'd2, 0, 32'h0, rdv, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0);
      e = model(a, 1, 0, 2'd2, 0, 32'h0, rdv, 2'b00, 2'b00);
      n_checks++; if (o_wait != 0) $display("FAIL b2b%0d_accept_wait got=%0d exp=0", i, o_wait); else n_pass++;
      n_checks++; if (o_result !== e.result || o_lat != 4) $display("FAIL b2b%0d_result got=%h/%0d exp=%h/4", i, o_result, o_lat, e.result); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic late;
    in_valid = 1; addr = 32'h8000_0040; mem_read = 1; mem_write = 0; size = 2'd2; is_unsigned = 0;
    @(negedge clk);
    in_valid = 0;
    n = 0;
    while (!rready && n < 20) begin grant = req; arready = arvalid; @(negedge clk); n++; end
    n_checks++; if (rready !== 1'b1) $display("FAIL rmid_reached_rdata got=%b exp=1", rready); else n_pass++;
    #2 rstn = 0;
    #1;
    n_checks++; if ({out_valid, req, arvalid, rready, awvalid, wvalid, bready, fault, in_ready} !== 9'h0) $display("FAIL rmid_ctrl got=%b exp=0", {out_valid, req, arvalid, rready, awvalid, wvalid, bready, fault, in_ready}); else n_pass++;
    n_checks++; if (result !== 32'h0 || fault_cause !== 2'd0 || region_sel !== 2'b00) $display("FAIL rmid_data got=%h/%0d/%b exp=0/0/00", result, fault_cause, region_sel); else n_pass++;
    @(negedge clk);
    clear_slave();
    rstn = 1;
    late = 0;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; rdata = 32'h5555_AAAA;
      @(negedge clk);
      if (out_valid) late = 1;
    end
    clear_slave();
    n_checks++; if (late !== 1'b0) $display("FAIL rmid_no_completion got=%b exp=0", late); else n_pass++;
    run_txn(32'h8000_0042, 1, 0, 2'd1, 1, 32'h0, 32'hBEEF_0000, 2'b00, 2'b00, 0, 1, 2, 0, 0, 0, 0);
    n_checks++; if (o_result !== 32'h0000_BEEF || o_cause !== 2'd0 || o_timeout !== 1'b0) $display("FAIL rmid_next_load got=%h/%0d exp=0000beef/0", o_result, o_cause); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_store_split();
    test_fault_paths();
    test_bus_error();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
